nasti_cmd_sched: RTL and testbench



---
 rtl/nasti_ddrx_pkg.sv | 55 +++++
 rtl/nasti_cmd_sched.sv | 148 ++++++++++++++
 tb/tb_nasti_cmd_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_ddrx_pkg.sv
// Shared types and constants for the NASTI-to-DDR command path.
// The command, write-beat and response layouts match the packed FIFO words.
package nasti_ddrx_pkg;

    localparam int NASTI_ID_W   = 4;
    localparam int NASTI_ADDR_W = 32;
    localparam int NASTI_DATA_W = 64;

    typedef struct packed {
        logic [NASTI_ID_W-1:0]   id;
        logic [NASTI_ADDR_W-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
    } nasti_ar_t;

    typedef struct packed {
        logic [NASTI_ID_W-1:0]   id;
        logic [NASTI_ADDR_W-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
    } nasti_aw_t;

    typedef struct packed {
        logic [NASTI_DATA_W-1:0]   data;
        logic [NASTI_DATA_W/8-1:0] strb;
    } nasti_w_t;

    typedef struct packed {
        logic [NASTI_ID_W-1:0] id;
        logic [1:0]            resp;
    } nasti_b_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        WR_CMD  = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } sched_state_t;

    function automatic logic burst_is_rsvd(input logic [1:0] burst);
        return burst == BURST_RSVD;
    endfunction

endpackage

// File: rtl/nasti_cmd_sched.sv
// Round-robin AR/AW command scheduler feeding the DDR backend; streams write
// beats from the W FIFO and returns the write response to the B FIFO.
module nasti_cmd_sched
    import nasti_ddrx_pkg::*;
#(
    parameter int C_ID_WIDTH   = 4,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                              core_clk,
    input  logic                              core_rst,
    input  logic [C_ID_WIDTH+C_ADDR_WIDTH+12:0] rdata_ar,
    input  logic                              rempty_ar,
    output logic                              rinc_ar,
    input  logic [C_ID_WIDTH+C_ADDR_WIDTH+12:0] rdata_aw,
    input  logic                              rempty_aw,
    output logic                              rinc_aw,
    input  logic [C_DATA_WIDTH+C_DATA_WIDTH/8-1:0] rdata_w,
    input  logic                              rempty_w,
    output logic                              rinc_w,
    output logic [C_ID_WIDTH+1:0]             wdata_b,
    input  logic                              wfull_b,
    output logic                              winc_b,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output logic                              cmd_write,
    output logic [C_ID_WIDTH-1:0]             cmd_id,
    output logic [C_ADDR_WIDTH-1:0]           cmd_addr,
    output logic [7:0]                        cmd_len,
    output logic [2:0]                        cmd_size,
    output logic [1:0]                        cmd_burst,
    output logic                              wd_valid,
    input  logic                              wd_ready,
    output logic [C_DATA_WIDTH-1:0]           wd_data,
    output logic [C_DATA_WIDTH/8-1:0]         wd_strb,
    output logic                              wd_last
);

    localparam int CMD_W  = C_ID_WIDTH + C_ADDR_WIDTH + 13;
    localparam int STRB_W = C_DATA_WIDTH / 8;

    sched_state_t state;
    logic         prefer_wr;
    logic         drain;
    logic [7:0]   beat_cnt;
    logic [1:0]   resp;

    logic                    grant_rd;
    logic                    grant_wr;
    logic                    w_pop;
    logic [CMD_W-1:0]        sel;
    logic [C_ID_WIDTH-1:0]   sel_id;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]              sel_len;
    logic [2:0]              sel_size;
    logic [1:0]              sel_burst;

    // Arbitration: a lone requester wins, otherwise prefer_wr breaks the tie.
    always_comb begin
        grant_wr = (state == IDLE) && !rempty_aw && (rempty_ar || prefer_wr);
        grant_rd = (state == IDLE) && !rempty_ar && !grant_wr;
        sel      = grant_wr ? rdata_aw : rdata_ar;
    end

    assign sel_id    = sel[CMD_W-1 -: C_ID_WIDTH];
    assign sel_addr  = sel[C_ADDR_WIDTH+12:13];
    assign sel_len   = sel[12:5];
    assign sel_size  = sel[4:2];
    assign sel_burst = sel[1:0];

    // Pops and pushes are suppressed while reset is held so an abandoned
    // burst cannot consume FIFO entries on the reset edge.
    assign rinc_ar   = grant_rd && !core_rst;
    assign rinc_aw   = grant_wr && !core_rst;
    assign cmd_valid = ((state == RD_CMD) || (state == WR_CMD)) && !core_rst;

    assign wd_valid = (state == WR_DATA) && !drain && !rempty_w && !core_rst;
    assign w_pop    = (state == WR_DATA) && !rempty_w && (drain || wd_ready) && !core_rst;
    assign rinc_w   = w_pop;
    assign wd_data  = wd_valid ? rdata_w[C_DATA_WIDTH+STRB_W-1:STRB_W] : '0;
    assign wd_strb  = wd_valid ? rdata_w[STRB_W-1:0] : '0;
    assign wd_last  = wd_valid && (beat_cnt == 8'd0);

    assign winc_b  = (state == WR_RESP) && !wfull_b && !core_rst;
    assign wdata_b = (state == WR_RESP) ? {cmd_id, resp} : '0;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state     <= IDLE;
            prefer_wr <= 1'b0;
            drain     <= 1'b0;
            beat_cnt  <= 8'd0;
            resp      <= RESP_OKAY;
            cmd_write <= 1'b0;
            cmd_id    <= '0;
            cmd_addr  <= '0;
            cmd_len   <= 8'd0;
            cmd_size  <= 3'd0;
            cmd_burst <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd || grant_wr) begin
                        cmd_write <= grant_wr;
                        cmd_id    <= sel_id;
                        cmd_addr  <= sel_addr;
                        cmd_len   <= sel_len;
                        cmd_size  <= sel_size;
                        cmd_burst <= sel_burst;
                        prefer_wr <= grant_rd;
                        // Reserved-burst writes never reach the backend; their
                        // data is discarded and the master gets SLVERR.
                        if (grant_wr && burst_is_rsvd(sel_burst)) begin
                            state    <= WR_DATA;
                            drain    <= 1'b1;
                            beat_cnt <= sel_len;
                            resp     <= RESP_SLVERR;
                        end else begin
                            state <= grant_wr ? WR_CMD : RD_CMD;
                            drain <= 1'b0;
                            resp  <= RESP_OKAY;
                        end
                    end
                end
                RD_CMD: begin
                    if (cmd_ready) state <= IDLE;
                end
                WR_CMD: begin
                    if (cmd_ready) begin
                        state    <= WR_DATA;
                        beat_cnt <= cmd_len;
                    end
                end
                WR_DATA: begin
                    if (w_pop) begin
                        if (beat_cnt == 8'd0) state <= WR_RESP;
                        else                  beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                WR_RESP: begin
                    if (winc_b) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nasti_cmd_sched.sv
// Randomized bench for nasti_cmd_sched: FIFO models on every port and a
// grant-order reference model predicting commands, write beats and responses.
module tb_nasti_cmd_sched;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int CW  = IDW + AW + 13;

    logic              core_clk = 1'b0;
    logic              core_rst = 1'b1;
    logic [CW-1:0]     rdata_ar = '0;
    logic              rempty_ar = 1'b1;
    logic              rinc_ar;
    logic [CW-1:0]     rdata_aw = '0;
    logic              rempty_aw = 1'b1;
    logic              rinc_aw;
    logic [DW+SW-1:0]  rdata_w = '0;
    logic              rempty_w = 1'b1;
    logic              rinc_w;
    logic [IDW+1:0]    wdata_b;
    logic              wfull_b = 1'b0;
    logic              winc_b;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic              cmd_write;
    logic [IDW-1:0]    cmd_id;
    logic [AW-1:0]     cmd_addr;
    logic [7:0]        cmd_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;
    logic              wd_valid;
    logic              wd_ready = 1'b0;
    logic [DW-1:0]     wd_data;
    logic [SW-1:0]     wd_strb;
    logic              wd_last;

    nasti_cmd_sched #(.C_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .rdata_ar(rdata_ar), .rempty_ar(rempty_ar), .rinc_ar(rinc_ar),
        .rdata_aw(rdata_aw), .rempty_aw(rempty_aw), .rinc_aw(rinc_aw),
        .rdata_w(rdata_w), .rempty_w(rempty_w), .rinc_w(rinc_w),
        .wdata_b(wdata_b), .wfull_b(wfull_b), .winc_b(winc_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .wd_strb(wd_strb), .wd_last(wd_last)
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
    } cmd_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } beat_t;

    typedef struct packed {
        logic wr;
        cmd_t c;
    } exp_cmd_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        logic          drain;
    } exp_beat_t;

    cmd_t           ar_q[$];
    cmd_t           aw_q[$];
    beat_t          w_q[$];
    exp_cmd_t       exp_cmd_q[$];
    exp_beat_t      exp_beat_q[$];
    logic [IDW+1:0] exp_b_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          w_pops   = 0;
    bit          rnd_bp   = 1'b0;
    bit          prev_cmd_wait = 1'b0;
    logic [63:0] prev_cmd = '0;
    bit          prev_wd_wait = 1'b0;
    logic [63:0] prev_wd_data = '0;
    logic [63:0] prev_wd_ctl = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cmd_vec();
        return 64'({cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst});
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.id    = 4'($urandom());
        c.addr  = $urandom();
        c.len   = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 4));
        c.size  = 3'($urandom());
        c.burst = 2'($urandom());
        return c;
    endfunction

    task automatic push_write(input cmd_t c);
        beat_t b;
        aw_q.push_back(c);
        for (int i = 0; i <= int'(c.len); i++) begin
            b.data = {$urandom(), $urandom()};
            b.strb = 8'($urandom());
            w_q.push_back(b);
        end
    endtask

    task automatic clear_all();
        ar_q.delete(); aw_q.delete(); w_q.delete();
        exp_cmd_q.delete(); exp_beat_q.delete(); exp_b_q.delete();
    endtask

    // Reference model: replays the arbitration rules over the preloaded
    // queues and lists every backend command, beat and response in order.
    task automatic build_expected();
        cmd_t      a[$];
        cmd_t      w[$];
        cmd_t      c;
        exp_cmd_t  ec;
        exp_beat_t eb;
        bit        pref = 1'b0;
        bit        gw;
        int        wi = 0;
        a = ar_q;
        w = aw_q;
        while (a.size() != 0 || w.size() != 0) begin
            gw = (w.size() != 0) && (a.size() == 0 || pref);
            if (gw) begin
                c = w.pop_front();
                pref = 1'b0;
                if (c.burst != 2'b11) begin
                    ec.wr = 1'b1; ec.c = c;
                    exp_cmd_q.push_back(ec);
                end
                for (int i = 0; i <= int'(c.len); i++) begin
                    eb.data  = w_q[wi].data;
                    eb.strb  = w_q[wi].strb;
                    eb.last  = (i == int'(c.len));
                    eb.drain = (c.burst == 2'b11);
                    exp_beat_q.push_back(eb);
                    wi++;
                end
                exp_b_q.push_back({c.id, (c.burst == 2'b11) ? 2'b10 : 2'b00});
            end else begin
                c = a.pop_front();
                pref = 1'b1;
                ec.wr = 1'b0; ec.c = c;
                exp_cmd_q.push_back(ec);
            end
        end
    endtask

    task automatic drive_inputs();
        rempty_ar = (ar_q.size() == 0);
        rdata_ar  = rempty_ar ? '0 : CW'(ar_q[0]);
        rempty_aw = (aw_q.size() == 0);
        rdata_aw  = rempty_aw ? '0 : CW'(aw_q[0]);
        rempty_w  = (w_q.size() == 0);
        rdata_w   = rempty_w ? '0 : {w_q[0].data, w_q[0].strb};
        if (rnd_bp) begin
            cmd_ready = ($urandom_range(0, 2) == 0);
            wd_ready  = ($urandom_range(0, 1) == 0);
            wfull_b   = ($urandom_range(0, 2) == 0);
        end else begin
            cmd_ready = 1'b1;
            wd_ready  = 1'b1;
            wfull_b   = 1'b0;
        end
    endtask

    task automatic observe();
        exp_cmd_t  ec;
        exp_beat_t eb;
        logic [IDW+1:0] ebr;
        if (core_rst) begin
            prev_cmd_wait = 1'b0;
            prev_wd_wait  = 1'b0;
            return;
        end
        if (prev_cmd_wait) chk("cmd_hold", cmd_vec(), prev_cmd);
        if (prev_wd_wait) begin
            chk("wd_hold_data", 64'(wd_data), prev_wd_data);
            chk("wd_hold_ctl", 64'({wd_valid, wd_last, wd_strb}), prev_wd_ctl);
        end
        prev_cmd_wait = cmd_valid && !cmd_ready;
        prev_cmd      = cmd_vec();
        prev_wd_wait  = wd_valid && !wd_ready;
        prev_wd_data  = 64'(wd_data);
        prev_wd_ctl   = 64'({wd_valid, wd_last, wd_strb});

        if (rinc_ar) begin
            chk("ar_pop_nonempty", 64'(rempty_ar), 64'(0));
            if (ar_q.size() != 0) void'(ar_q.pop_front());
        end
        if (rinc_aw) begin
            chk("aw_pop_nonempty", 64'(rempty_aw), 64'(0));
            if (aw_q.size() != 0) void'(aw_q.pop_front());
        end
        if (cmd_valid && cmd_ready) begin
            if (exp_cmd_q.size() == 0) chk("extra_cmd", 64'(cmd_valid), 64'(0));
            else begin
                ec = exp_cmd_q.pop_front();
                chk("cmd_fields", cmd_vec(), 64'({1'b1, ec.wr, ec.c.id, ec.c.addr, ec.c.len, ec.c.size, ec.c.burst}));
            end
        end
        if (wd_valid && wd_ready) chk("wd_accept_pops", 64'(rinc_w), 64'(1));
        if (rinc_w) begin
            w_pops++;
            chk("w_pop_nonempty", 64'(rempty_w), 64'(0));
            if (exp_beat_q.size() == 0) chk("extra_w_pop", 64'(rinc_w), 64'(0));
            else begin
                eb = exp_beat_q.pop_front();
                chk("wd_valid_on_pop", 64'(wd_valid), 64'(!eb.drain));
                if (wd_valid) begin
                    chk("wd_data", 64'(wd_data), 64'(eb.data));
                    chk("wd_strb_last", 64'({wd_strb, wd_last}), 64'({eb.strb, eb.last}));
                end
            end
            if (w_q.size() != 0) void'(w_q.pop_front());
        end
        if (winc_b) begin
            chk("b_not_full", 64'(wfull_b), 64'(0));
            if (exp_b_q.size() == 0) chk("extra_b_push", 64'(winc_b), 64'(0));
            else begin
                ebr = exp_b_q.pop_front();
                chk("b_word", 64'(wdata_b), 64'(ebr));
            end
        end
    endtask

    task automatic step(input bit rst_v);
        @(negedge core_clk);
        core_rst = rst_v;
        drive_inputs();
        #1;
        observe();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_cmd"}, cmd_vec(), 64'(0));
        chk({tag, "_wd_data"}, 64'(wd_data), 64'(0));
        chk({tag, "_misc"}, 64'({rinc_ar, rinc_aw, rinc_w, winc_b, wdata_b, wd_valid, wd_strb, wd_last}), 64'(0));
    endtask

    task automatic do_reset();
        step(1'b1);
        step(1'b1);
        check_zero_outputs("rst");
    endtask

    task automatic run_batch(input int budget);
        int cyc = 0;
        do_reset();
        build_expected();
        while ((exp_cmd_q.size() + exp_beat_q.size() + exp_b_q.size()) != 0 && cyc < budget) begin
            step(1'b0);
            cyc++;
        end
        chk("batch_drained", 64'(exp_cmd_q.size() + exp_beat_q.size() + exp_b_q.size()), 64'(0));
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("fifos_consumed", 64'(ar_q.size() + aw_q.size() + w_q.size()), 64'(0));
    endtask

    initial begin
        cmd_t c;
        logic [7:0] pop_bits, b_bits, last_bits;
        int cyc;

        // Single read: pop at T0, command at T1, idle at T2.
        clear_all();
        rnd_bp = 1'b0;
        c = '{id: 4'd3, addr: 32'h100, len: 8'd0, size: 3'd3, burst: 2'd1};
        ar_q.push_back(c);
        do_reset();
        build_expected();
        step(1'b0);
        chk("rd_t0_rinc_ar", 64'({rinc_ar, cmd_valid}), 64'(2'b10));
        step(1'b0);
        chk("rd_t1_cmd", 64'({cmd_valid, cmd_write, cmd_id, cmd_addr}), 64'({1'b1, 1'b0, 4'd3, 32'h100}));
        step(1'b0);
        chk("rd_t2_idle", 64'({cmd_valid, rinc_ar}), 64'(0));

        // Write len=3 with four beats ready: four back-to-back pops then B.
        clear_all();
        c = '{id: 4'd5, addr: 32'h200, len: 8'd3, size: 3'd3, burst: 2'd1};
        push_write(c);
        do_reset();
        build_expected();
        pop_bits = '0; b_bits = '0; last_bits = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            pop_bits[i]  = rinc_w;
            b_bits[i]    = winc_b;
            last_bits[i] = wd_last;
        end
        chk("wr_pop_pattern", 64'(pop_bits), 64'(8'h3C));
        chk("wr_last_pattern", 64'(last_bits), 64'(8'h20));
        chk("wr_b_pattern", 64'(b_bits), 64'(8'h40));

        // Three reads and three writes queued together alternate R,W,...
        clear_all();
        for (int i = 0; i < 3; i++) begin
            c = rand_cmd(); c.len = 8'd0; c.burst = 2'd1;
            ar_q.push_back(c);
            c = rand_cmd(); c.len = 8'($urandom_range(0, 2)); c.burst = 2'd1;
            push_write(c);
        end
        run_batch(2000);

        // Reserved-burst write is drained with SLVERR; reserved read passes.
        clear_all();
        c = '{id: 4'd9, addr: 32'h300, len: 8'd1, size: 3'd2, burst: 2'b11};
        push_write(c);
        c = '{id: 4'd2, addr: 32'h400, len: 8'd4, size: 3'd2, burst: 2'b11};
        ar_q.push_back(c);
        run_batch(2000);

        // Full-length burst under backpressure.
        clear_all();
        rnd_bp = 1'b1;
        c = rand_cmd(); c.len = 8'd255; c.burst = 2'd1;
        push_write(c);
        c = rand_cmd(); c.len = 8'd0; c.burst = 2'd0;
        push_write(c);
        run_batch(5000);

        // Reset after the second beat of a four-beat burst.
        clear_all();
        rnd_bp = 1'b0;
        c = '{id: 4'd7, addr: 32'h500, len: 8'd3, size: 3'd3, burst: 2'd1};
        push_write(c);
        do_reset();
        build_expected();
        w_pops = 0;
        cyc = 0;
        while (w_pops < 2 && cyc < 20) begin
            step(1'b0);
            cyc++;
        end
        chk("mid_reached_beat2", 64'(w_pops), 64'(2));
        step(1'b1);
        chk("mid_rst_no_pop", 64'({rinc_w, winc_b}), 64'(0));
        step(1'b1);
        check_zero_outputs("mid_rst");
        exp_cmd_q.delete(); exp_beat_q.delete(); exp_b_q.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk("post_rst_quiet", 64'({rinc_w, winc_b, cmd_valid, wd_valid}), 64'(0));
        end

        // Randomized batches with random backpressure.
        for (int n = 0; n < 25; n++) begin
            clear_all();
            rnd_bp = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) ar_q.push_back(rand_cmd());
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) push_write(rand_cmd());
            run_batch(20000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
